mem_arbiter: RTL

- Shares the single-port byte memory between two requesters: the host command engine (UART read/write commands) and the gpu's sprite fetch/framebuffer write port.
- Replaces ad-hoc OR-merging of the two request buses with explicit request/grant handshakes, round-robin fairness and read-data routing.
- Sits between the command controller, the gpu and the memory instance.
- Memory contract: the access is latched at the clock edge where mem_read/mem_write is high; read_byte is valid in the following cycle.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 31 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the memory arbiter: requester ids, default bus
// widths and a small helper for round-robin selection.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Requester identifiers; the encoding doubles as the read-return owner tag.
    typedef enum logic {
        REQ_HOST = 1'b0,
        REQ_GPU  = 1'b1
    } req_id_e;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // The requester that is not `id`; used to favour the loser of the last grant.
    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_HOST) ? REQ_GPU : REQ_HOST;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational 2-way round-robin selector.
//   h_elig, g_elig : requester is eligible this cycle
//   last_winner    : requester granted most recently
//   winner         : selected requester (meaningful only when valid=1)
//   valid          : at least one requester is eligible
// -----------------------------------------------------------------------------
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic    h_elig,
    input  logic    g_elig,
    input  req_id_e last_winner,
    output req_id_e winner,
    output logic    valid
);

    // NOTE: every output gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        winner = REQ_HOST;
        valid  = h_elig | g_elig;
        if (h_elig && g_elig) begin
            winner = other_req(last_winner);
        end else if (g_elig) begin
            winner = REQ_GPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares a single-port byte memory between the host command engine and the
// gpu with request/grant handshakes, round-robin fairness and read-data
// routing back to the issuing requester.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   h_req/h_we/h_addr/h_wdata  host access request (held until h_gnt)
//   h_gnt                      pulse: host access issued this cycle
//   h_rvalid/h_rdata           pulse: host read data returned
//   g_*                        same set for the gpu
//   mem_read/mem_write         memory strobes (never both high)
//   mem_addr/mem_write_byte    memory address and write data
//   mem_read_byte              memory read data, valid the cycle after mem_read
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [DATA_WIDTH-1:0] h_rdata,

    input  logic                  g_req,
    input  logic                  g_we,
    input  logic [ADDR_WIDTH-1:0] g_addr,
    input  logic [DATA_WIDTH-1:0] g_wdata,
    output logic                  g_gnt,
    output logic                  g_rvalid,
    output logic [DATA_WIDTH-1:0] g_rdata,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_byte,
    input  logic [DATA_WIDTH-1:0] mem_read_byte
);

    // Issue stage
    logic                  h_gnt_d,          h_gnt_q;
    logic                  g_gnt_d,          g_gnt_q;
    logic                  mem_read_d,       mem_read_q;
    logic                  mem_write_d,      mem_write_q;
    logic [ADDR_WIDTH-1:0] mem_addr_d,       mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_write_byte_d, mem_write_byte_q;
    req_id_e               last_winner_d,    last_winner_q;

    // Read-return tag, travels alongside mem_read
    logic                  rd_valid_d,       rd_valid_q;
    req_id_e               rd_owner_d,       rd_owner_q;

    // Return stage
    logic                  h_rvalid_d,       h_rvalid_q;
    logic                  g_rvalid_d,       g_rvalid_q;
    logic [DATA_WIDTH-1:0] h_rdata_d,        h_rdata_q;
    logic [DATA_WIDTH-1:0] g_rdata_d,        g_rdata_q;

    logic                  h_elig, g_elig;
    logic                  pick_valid;
    req_id_e               pick_winner;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // A requester granted last cycle sits out one cycle, giving it time to
    // drop req or present its next access before it can win again.
    assign h_elig = h_req & ~h_gnt_q;
    assign g_elig = g_req & ~g_gnt_q;

    rr_pick2 u_pick (
        .h_elig      (h_elig),
        .g_elig      (g_elig),
        .last_winner (last_winner_q),
        .winner      (pick_winner),
        .valid       (pick_valid)
    );

    assign sel_we    = (pick_winner == REQ_GPU) ? g_we    : h_we;
    assign sel_addr  = (pick_winner == REQ_GPU) ? g_addr  : h_addr;
    assign sel_wdata = (pick_winner == REQ_GPU) ? g_wdata : h_wdata;

    always_comb begin
        h_gnt_d          = pick_valid && (pick_winner == REQ_HOST);
        g_gnt_d          = pick_valid && (pick_winner == REQ_GPU);
        mem_read_d       = pick_valid && !sel_we;
        mem_write_d      = pick_valid &&  sel_we;
        mem_addr_d       = pick_valid ? sel_addr : '0;
        mem_write_byte_d = (pick_valid && sel_we) ? sel_wdata : '0;
        last_winner_d    = pick_valid ? pick_winner : last_winner_q;

        rd_valid_d       = mem_read_d;
        rd_owner_d       = pick_winner;

        h_rvalid_d       = rd_valid_q && (rd_owner_q == REQ_HOST);
        g_rvalid_d       = rd_valid_q && (rd_owner_q == REQ_GPU);

        // Capture returning data so rdata holds until the owner's next rvalid.
        h_rdata_d        = h_rvalid_q ? mem_read_byte : h_rdata_q;
        g_rdata_d        = g_rvalid_q ? mem_read_byte : g_rdata_q;
    end

    // NOTE: reset is sampled on the clock edge only (no rst_n in the
    // sensitivity list), and the holding registers are cleared too so
    // rdata reads 0 after reset rather than a stale byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_gnt_q          <= 1'b0;
            g_gnt_q          <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_byte_q <= '0;
            last_winner_q    <= REQ_GPU;
            rd_valid_q       <= 1'b0;
            rd_owner_q       <= REQ_HOST;
            h_rvalid_q       <= 1'b0;
            g_rvalid_q       <= 1'b0;
            h_rdata_q        <= '0;
            g_rdata_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            h_gnt_q          <= h_gnt_d;
            g_gnt_q          <= g_gnt_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_byte_q <= mem_write_byte_d;
            last_winner_q    <= last_winner_d;
            rd_valid_q       <= rd_valid_d;
            rd_owner_q       <= rd_owner_d;
            h_rvalid_q       <= h_rvalid_d;
            g_rvalid_q       <= g_rvalid_d;
            h_rdata_q        <= h_rdata_d;
            g_rdata_q        <= g_rdata_d;
        end
    end

    assign h_gnt          = h_gnt_q;
    assign g_gnt          = g_gnt_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_byte = mem_write_byte_q;
    assign h_rvalid       = h_rvalid_q;
    assign g_rvalid       = g_rvalid_q;

    // The memory presents its byte in the rvalid cycle itself, so the live
    // byte is forwarded then and the captured copy is shown afterwards.
    assign h_rdata = h_rvalid_q ? mem_read_byte : h_rdata_q;
    assign g_rdata = g_rvalid_q ? mem_read_byte : g_rdata_q;

endmodule
